// File: rtl/adc_sar_osr_ctrl_pkg.sv
// Shared definitions for the oversampling SAR controller: FSM encodings,
// latched configuration record and the configuration clamp helper.
package adc_sar_osr_ctrl_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SAMPLE = 3'd1;
  localparam logic [2:0] ST_CONV   = 3'd2;
  localparam logic [2:0] ST_ACCUM  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  typedef struct packed {
    logic [2:0] osr;
    logic [1:0] avg;
    logic [3:0] smp;
  } cfg_t;

  // Saturate the log2 fields to what the datapath was sized for; a zero-length
  // sample phase still samples for one cycle.
  function automatic cfg_t clamp_cfg(input logic [2:0] osr, input logic [1:0] avg,
                                     input logic [3:0] smp, input int max_osr,
                                     input int max_avg);
    cfg_t c;
    c.osr = (int'(osr) > max_osr) ? 3'(max_osr) : osr;
    c.avg = (int'(avg) > max_avg) ? 2'(max_avg) : avg;
    c.smp = (smp == 4'd0) ? 4'd1 : smp;
    return c;
  endfunction

endpackage

// File: rtl/adc_sar_osr_ctrl_lsb_vote.sv
// Majority vote over 2^avg repeated comparisons of one LSB decision.
// Ties resolve to 1; counters self-clear on the last repeat.
module adc_lsb_vote
  import adc_sar_osr_ctrl_pkg::*;
#(
  parameter int MAX_AVG_LOG2 = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       comp,
  input  logic [1:0] avg_log2,
  output logic       last,
  output logic       vote_bit
);
  localparam int CW = MAX_AVG_LOG2 + 1;

  logic [CW-1:0] ones_q, rep_q, reps, ones_tot;

  always_comb begin
    reps     = CW'(1) << avg_log2;
    ones_tot = ones_q + CW'(comp);
    last     = en && (rep_q == reps - CW'(1));
    // 2*ones >= R, current comparator sample included
    vote_bit = {ones_tot, 1'b0} >= {1'b0, reps};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_q <= '0;
      rep_q  <= '0;
    end else if (clr || last) begin
      ones_q <= '0;
      rep_q  <= '0;
    end else if (en) begin
      ones_q <= ones_tot;
      rep_q  <= rep_q + CW'(1);
    end
  end

endmodule

// File: rtl/adc_sar_osr_ctrl.sv
// Oversampling SAR sequencer: sample/convert with LSB majority voting,
// accumulate 2^osr codes and hand a left-aligned sum over valid/ready.
module adc_sar_osr_ctrl
  import adc_sar_osr_ctrl_pkg::*;
#(
  parameter int RES_BITS     = 12,
  parameter int AVG_BITS     = 4,
  parameter int MAX_OSR_LOG2 = 4,
  parameter int MAX_AVG_LOG2 = 3,
  parameter int SUM_W        = RES_BITS + MAX_OSR_LOG2
) (
  input  logic                clk_dig_in,
  input  logic                rst,
  input  logic                start_in,
  input  logic                cont_mode_in,
  input  logic [2:0]          cfg_osr_log2_in,
  input  logic [1:0]          cfg_avg_log2_in,
  input  logic [3:0]          cfg_sample_cycles_in,
  input  logic                comparator_in,
  output logic                sample_out,
  output logic [RES_BITS-1:0] dac_code_out,
  output logic                busy_out,
  output logic [SUM_W-1:0]    result_out,
  output logic                result_valid_out,
  input  logic                result_ready_in,
  output logic                overrange_out
);
  localparam int KW = $clog2(RES_BITS);
  localparam int CW = MAX_OSR_LOG2 + 1;

  logic [2:0]          state_q;
  cfg_t                cfg_q, cfg_in;
  logic [3:0]          smp_cnt_q;
  logic [KW-1:0]       k_q;
  logic [RES_BITS-1:0] code_q, trial;
  logic [SUM_W-1:0]    acc_q, acc_nxt, result_nxt;
  logic [CW-1:0]       conv_cnt_q, conv_tgt;
  logic                lsb_phase, vote_en, vote_last, vote_bit;

  always_comb begin
    cfg_in     = clamp_cfg(cfg_osr_log2_in, cfg_avg_log2_in, cfg_sample_cycles_in,
                           MAX_OSR_LOG2, MAX_AVG_LOG2);
    trial      = RES_BITS'(1) << k_q;
    lsb_phase  = int'(k_q) < AVG_BITS;
    vote_en    = (state_q == ST_CONV) && lsb_phase;
    acc_nxt    = acc_q + SUM_W'(code_q);
    conv_tgt   = CW'(1) << cfg_q.osr;
    // left-align so every osr setting shares the same full-scale
    result_nxt = acc_nxt << (MAX_OSR_LOG2 - int'(cfg_q.osr));
  end

  assign sample_out   = (state_q == ST_SAMPLE);
  assign busy_out     = (state_q != ST_IDLE);
  assign dac_code_out = (state_q == ST_CONV) ? (code_q | trial) : '0;

  adc_lsb_vote #(.MAX_AVG_LOG2(MAX_AVG_LOG2)) u_vote (
    .clk      (clk_dig_in),
    .rst      (rst),
    .clr      (state_q != ST_CONV),
    .en       (vote_en),
    .comp     (comparator_in),
    .avg_log2 (cfg_q.avg),
    .last     (vote_last),
    .vote_bit (vote_bit)
  );

  always_ff @(posedge clk_dig_in or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      cfg_q            <= '0;
      smp_cnt_q        <= '0;
      k_q              <= '0;
      code_q           <= '0;
      acc_q            <= '0;
      conv_cnt_q       <= '0;
      result_out       <= '0;
      result_valid_out <= 1'b0;
      overrange_out    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_in) begin
            cfg_q         <= cfg_in;
            overrange_out <= 1'b0;
            smp_cnt_q     <= '0;
            state_q       <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          code_q <= '0;
          if (smp_cnt_q == cfg_q.smp - 4'd1) begin
            smp_cnt_q <= '0;
            k_q       <= KW'(RES_BITS - 1);
            state_q   <= ST_CONV;
          end else begin
            smp_cnt_q <= smp_cnt_q + 4'd1;
          end
        end
        ST_CONV: begin
          if (!lsb_phase || vote_last) begin
            code_q[k_q] <= lsb_phase ? vote_bit : comparator_in;
            if (k_q == '0) state_q <= ST_ACCUM;
            else           k_q     <= k_q - KW'(1);
          end
        end
        ST_ACCUM: begin
          acc_q      <= acc_nxt;
          conv_cnt_q <= conv_cnt_q + CW'(1);
          if (&code_q) overrange_out <= 1'b1;
          if (conv_cnt_q + CW'(1) == conv_tgt) begin
            result_out       <= result_nxt;
            result_valid_out <= 1'b1;
            state_q          <= ST_DONE;
          end else begin
            state_q <= ST_SAMPLE;
          end
        end
        ST_DONE: begin
          // stall holds everything; nothing samples until the handshake
          if (result_ready_in) begin
            result_valid_out <= 1'b0;
            acc_q            <= '0;
            conv_cnt_q       <= '0;
            state_q          <= cont_mode_in ? ST_SAMPLE : ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_sar_osr_ctrl.sv
// Scoreboarded bench: an ideal comparator (vin >= dac code) closes the SAR
// loop, optionally overridden on the bit-0 trial to script LSB votes.
module tb_adc_sar_osr_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, cont = 1'b0, ready = 1'b1;
  logic [2:0]  cfg_osr = 3'd0;
  logic [1:0]  cfg_avg = 2'd0;
  logic [3:0]  cfg_smp = 4'd1;
  logic        comp;
  logic        sample, busy, valid, ovr;
  logic [11:0] dac;
  logic [15:0] result;

  logic [11:0] vin = 12'h000;
  logic        vote_ovr = 1'b0;
  logic [3:0]  vote_pat = 4'b0000;
  logic [1:0]  vote_idx = 2'd0;
  int          cyc = 0;
  int          total = 0, bad = 0;
  int          rise_cyc = 0;
  logic        vld_d = 1'b0;

  typedef struct { logic [15:0] res; logic ovr; int start; int lat; } exp_t;
  exp_t sb[$];

  adc_sar_osr_ctrl dut (
    .clk_dig_in(clk), .rst(rst), .start_in(start), .cont_mode_in(cont),
    .cfg_osr_log2_in(cfg_osr), .cfg_avg_log2_in(cfg_avg), .cfg_sample_cycles_in(cfg_smp),
    .comparator_in(comp), .sample_out(sample), .dac_code_out(dac), .busy_out(busy),
    .result_out(result), .result_valid_out(valid), .result_ready_in(ready),
    .overrange_out(ovr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign comp = (vote_ovr && dac[0]) ? vote_pat[vote_idx] : (vin >= dac);

  always @(posedge clk) begin
    if (sample)      vote_idx <= 2'd0;
    else if (dac[0]) vote_idx <= vote_idx + 2'd1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // monitor: pop one expectation per accepted result
  always @(negedge clk) begin
    exp_t e;
    if (valid && !vld_d) rise_cyc = cyc;
    vld_d = valid;
    if (valid && ready) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_unexpected: got %0h want none", result);
      end else begin
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("overrange", ovr, e.ovr);
        if (e.lat != 0) chk("latency", rise_cyc - e.start, e.lat);
      end
    end
  end

  task automatic do_start(output int st);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    st = cyc;
  endtask

  task automatic push(input logic [15:0] r, input logic o, input int st, input int lat);
    exp_t e;
    e.res = r; e.ovr = o; e.start = st; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk); n++;
    end
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL %s_timeout: got %0d pending want 0", name, sb.size());
      sb.delete();
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    #1;
    chk("rst_sample", sample, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dac", dac, 0);
    chk("rst_result", result, 0);
    chk("rst_valid", valid, 0);
    chk("rst_ovr", ovr, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // defaults, full-scale input
    vin = 12'hFFF;
    do_start(st);
    push(16'hFFF0, 1'b1, st, 14);
    wait_drain("t1", 40);

    // osr=2, only MSB kept
    vin = 12'h800; cfg_osr = 3'd2;
    do_start(st);
    chk("t2_ovr_cleared", ovr, 0);
    push(16'h8000, 1'b0, st, 56);
    wait_drain("t2", 100);

    // longer sample phase: osr=1, N=3
    vin = 12'h001; cfg_osr = 3'd1; cfg_smp = 4'd3;
    do_start(st);
    push(16'h0010, 1'b0, st, 32);
    wait_drain("t2b", 80);
    cfg_smp = 4'd1; cfg_osr = 3'd0;

    // LSB voting, avg=2: tie -> 1, then 1 of 4 -> 0
    cfg_avg = 2'd2; vin = 12'h555; vote_ovr = 1'b1;
    vote_pat = 4'b0011;
    do_start(st);
    push(16'h5550, 1'b0, st, 26);
    wait_drain("t3a", 60);
    vote_pat = 4'b0001;
    do_start(st);
    push(16'h5540, 1'b0, st, 26);
    wait_drain("t3b", 60);
    vote_ovr = 1'b0; cfg_avg = 2'd0;

    // continuous mode with a 10-cycle stall
    cont = 1'b1; ready = 1'b0; vin = 12'h3A7;
    do_start(st);
    push(16'h3A70, 1'b0, st, 14);
    for (int i = 0; i < 40 && !valid; i++) @(negedge clk);
    chk("t4_valid", valid, 1);
    vin = 12'h0F0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_hold_result", result, 16'h3A70);
      chk("t4_hold_valid", valid, 1);
      chk("t4_hold_sample", sample, 0);
      chk("t4_hold_busy", busy, 1);
    end
    @(posedge clk); #1 ready = 1'b1;
    @(posedge clk); #1;
    chk("t4_next_sample", sample, 1);
    cont = 1'b0;
    push(16'h0F00, 1'b0, cyc, 14);
    wait_drain("t4", 60);
    @(posedge clk); #1;
    chk("t4_idle", busy, 0);

    // reset mid-CONV at osr=3
    cfg_osr = 3'd3; vin = 12'hFFF;
    do_start(st);
    repeat (20) @(posedge clk);
    #1;
    chk("t5_busy_pre", busy, 1);
    chk("t5_ovr_pre", ovr, 1);
    rst = 1'b1;
    #1;
    chk("t5_sample", sample, 0);
    chk("t5_busy", busy, 0);
    chk("t5_dac", dac, 0);
    chk("t5_result", result, 0);
    chk("t5_valid", valid, 0);
    chk("t5_ovr", ovr, 0);
    @(posedge clk); #1 rst = 1'b0;
    vin = 12'h000;
    do_start(st);
    push(16'h0000, 1'b0, st, 112);
    wait_drain("t5", 200);

    // clamp osr=7 -> 4, N=0 -> 1; cfg churn mid-run ignored
    cfg_osr = 3'd7; cfg_smp = 4'd0; vin = 12'h123;
    do_start(st);
    push(16'h1230, 1'b0, st, 224);
    repeat (30) @(posedge clk);
    #1 cfg_osr = 3'd0; cfg_smp = 4'd5; cfg_avg = 2'd3;
    wait_drain("t6", 300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
